// File: rtl/cart_sdram_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cart_sdram_arb
// Purpose  : Shares one SDRAM command port between ROM-download writes (via a
//            small FIFO) and cartridge byte reads. Macro CART_RD_CACHE_EN adds
//            a single-entry read cache.
// Revision : 1.0 - initial release
// ============================================================================
module cart_sdram_arb #(
  parameter int SD_LAT     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        cart_rd,
  input  logic [14:0] cart_addr,
  output logic [7:0]  cart_do,
  output logic        cart_valid,
  input  logic        sd_ready,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_din,
  output logic        sd_we,
  output logic        sd_rd,
  input  logic [15:0] sd_dout,
  output logic        dl_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, WAIT = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rst_ok;
  logic [3:0]    cnt_q, cnt_d;
  logic          rd_op_q, rd_op_d;
  logic          rd_done_q, rd_done_d;
  logic          sd_we_q, sd_we_d, sd_rd_q, sd_rd_d;
  logic [24:0]   sd_addr_q, sd_addr_d;
  logic [15:0]   sd_din_q, sd_din_d;
  logic [7:0]    cart_do_q, cart_do_d;
  logic          cart_valid_q, cart_valid_d;
  logic          pending_q, pending_d;
  logic [14:0]   rd_addr_q, rd_addr_d;
  logic          cart_rd_q, dl_active_q;
  logic [14:0]   cart_addr_q;
  logic          dl_ovf_q, dl_ovf_d;
  logic [32:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty, fifo_full, push, pop;
  logic          req, hit, miss_req, dl_rise, dispatch_ok, rd_issue;
  logic [32:0]   head;
  logic          unused_dout;

  assign rst_ok      = sync_q[1];
  assign req         = cart_rd && (!cart_rd_q || (cart_addr != cart_addr_q));
  assign miss_req    = req && !hit;
  assign dl_rise     = dl_active && !dl_active_q;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign head        = fifo_mem_q[rd_ptr_q];
  assign unused_dout = ^sd_dout[15:8];

`ifdef CART_RD_CACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [14:0] cache_addr_q, cache_addr_d;

  // A hit only while nothing is in flight, so cart_do still holds the cached byte.
  assign hit = req && cache_vld_q && (cart_addr == cache_addr_q) &&
               (state_q == IDLE) && !pending_q && !dl_active;

  always_comb begin
    cache_vld_d  = cache_vld_q;
    cache_addr_d = cache_addr_q;
    if ((state_q == WAIT) && (cnt_q == 4'd0) && rd_op_q) begin
      cache_vld_d  = 1'b1;
      cache_addr_d = sd_addr_q[14:0];
    end
    if (dl_rise) cache_vld_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_addr_q <= cache_addr_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // The final WAIT cycle dispatches like IDLE so back-to-back commands are SD_LAT apart.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_op_d     = rd_op_q;
    rd_done_d   = 1'b0;
    sd_we_d     = 1'b0;
    sd_rd_d     = 1'b0;
    sd_addr_d   = sd_addr_q;
    sd_din_d    = sd_din_q;
    cart_do_d   = cart_do_q;
    pop         = 1'b0;
    rd_issue    = 1'b0;
    dispatch_ok = 1'b0;
    case (state_q)
      IDLE: dispatch_ok = 1'b1;
      WR, RD: begin
        state_d = WAIT;
        cnt_d   = 4'(SD_LAT - 2);
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = IDLE;
          dispatch_ok = 1'b1;
          if (rd_op_q) begin
            cart_do_d = sd_dout[7:0];
            rd_done_d = !(pending_q || miss_req);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (dispatch_ok && rst_ok && sd_ready) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        state_d   = WR;
        sd_we_d   = 1'b1;
        sd_addr_d = head[32:8];
        sd_din_d  = {head[7:0], head[7:0]};
        rd_op_d   = 1'b0;
      end else if (!dl_active && (pending_q || miss_req)) begin
        rd_issue  = 1'b1;
        state_d   = RD;
        sd_rd_d   = 1'b1;
        sd_addr_d = {10'b0, (miss_req ? cart_addr : rd_addr_q)};
        rd_op_d   = 1'b1;
      end
    end
  end

  always_comb begin
    pending_d    = pending_q;
    rd_addr_d    = rd_addr_q;
    cart_valid_d = cart_valid_q;
    if (miss_req) begin
      pending_d = 1'b1;
      rd_addr_d = cart_addr;
    end
    if (rd_issue) pending_d = 1'b0;
    if (rd_done_q || hit) cart_valid_d = 1'b1;
    if (miss_req || dl_rise) cart_valid_d = 1'b0;
  end

  always_comb begin
    push     = dl_wr && (!fifo_full || pop);
    dl_ovf_d = dl_ovf_q || (dl_wr && !push);
    wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {dl_addr, dl_data};
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_op_q      <= 1'b0;
      rd_done_q    <= 1'b0;
      sd_we_q      <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_addr_q    <= '0;
      sd_din_q     <= '0;
      cart_do_q    <= '0;
      cart_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      rd_addr_q    <= '0;
      cart_rd_q    <= 1'b0;
      cart_addr_q  <= '0;
      dl_active_q  <= 1'b0;
      dl_ovf_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sync_q       <= {sync_q[0], 1'b1};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_op_q      <= rd_op_d;
      rd_done_q    <= rd_done_d;
      sd_we_q      <= sd_we_d;
      sd_rd_q      <= sd_rd_d;
      sd_addr_q    <= sd_addr_d;
      sd_din_q     <= sd_din_d;
      cart_do_q    <= cart_do_d;
      cart_valid_q <= cart_valid_d;
      pending_q    <= pending_d;
      rd_addr_q    <= rd_addr_d;
      cart_rd_q    <= cart_rd;
      cart_addr_q  <= cart_addr;
      dl_active_q  <= dl_active;
      dl_ovf_q     <= dl_ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign cart_do    = cart_do_q;
  assign cart_valid = cart_valid_q;
  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign sd_we      = sd_we_q;
  assign sd_rd      = sd_rd_q;
  assign dl_ovf     = dl_ovf_q;

endmodule
`default_nettype wire
